// File: rtl/aca_error_recovery_if.sv
// Operand/result handshake bundle for the ACA error-recovery unit.
// The slave side is the recovery unit; the master side feeds operands and drains results.
interface aca_error_recovery_if #(
    parameter int WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH:0]   result_o;
    logic             err_o;
    logic [15:0]      err_cnt_o;

    modport slave (
        input  valid_i, add1_i, add2_i, ready_i,
        output ready_o, valid_o, result_o, err_o, err_cnt_o
    );

    modport master (
        output valid_i, add1_i, add2_i, ready_i,
        input  ready_o, valid_o, result_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/aca_error_recovery.sv
// Variable-latency exact adder: speculative windowed-carry sum, returned directly when
// no WIN-long propagate run exists, otherwise rippled exactly one WIN-bit block per cycle.
module aca_error_recovery #(
    parameter int WIDTH = 16,
    parameter int WIN   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    aca_error_recovery_if.slave bus
);
    localparam int NB = WIDTH / WIN;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REC, S_OUT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_res;
    logic             r_err;
    logic [15:0]      r_cnt;
    logic [BW-1:0]    r_blk;
    logic             r_c;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_cin;
    logic [WIDTH:0]   w_approx;
    logic             w_flag;
    logic             w_last;
    logic [IW-1:0]    w_base;
    logic [WIN:0]     w_slice;

    assign w_p = r_a ^ r_b;
    assign w_g = r_a & r_b;

    // Each carry-in only looks back WIN bits, starting from a zero carry.
    always_comb begin
        logic v_c;
        w_cin = '0;
        v_c   = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            v_c = 1'b0;
            for (int k = 0; k < WIDTH; k++) begin
                if ((k + WIN >= i) && (k < i))
                    v_c = w_g[k] | (w_p[k] & v_c);
            end
            w_cin[i] = v_c;
        end
    end

    assign w_approx = {w_cin[WIDTH], w_p ^ w_cin[WIDTH-1:0]};

    always_comb begin
        w_flag = 1'b0;
        for (int j = 0; j <= WIDTH - WIN; j++) begin
            if (&w_p[j +: WIN])
                w_flag = 1'b1;
        end
    end

    assign w_last  = (r_blk == BW'(NB - 1));
    assign w_base  = IW'(int'(r_blk) * WIN);
    assign w_slice = {1'b0, r_a[w_base +: WIN]} + {1'b0, r_b[w_base +: WIN]}
                   + {{WIN{1'b0}}, r_c};

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.valid_i) w_next = S_EVAL;
            S_EVAL:  w_next = w_flag ? S_REC : S_OUT;
            S_REC:   if (w_last) w_next = S_OUT;
            S_OUT:   if (bus.ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (r_state == S_IDLE);
        bus.valid_o = (r_state == S_OUT);
    end

    assign bus.result_o  = r_res;
    assign bus.err_o     = r_err;
    assign bus.err_cnt_o = r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
            r_blk <= '0;
            r_c   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_a <= bus.add1_i;
                        r_b <= bus.add2_i;
                    end
                end
                S_EVAL: begin
                    if (!w_flag) begin
                        r_res <= w_approx;
                        r_err <= 1'b0;
                    end else begin
                        r_c   <= 1'b0;
                        r_blk <= '0;
                        if (r_cnt != 16'hFFFF)
                            r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_REC: begin
                    r_res[w_base +: WIN] <= w_slice[WIN-1:0];
                    r_c                  <= w_slice[WIN];
                    if (w_last) begin
                        r_res[WIDTH] <= w_slice[WIN];
                        r_err        <= 1'b1;
                        r_blk        <= '0;
                    end else begin
                        r_blk <= r_blk + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aca_error_recovery.sv
// Scoreboard bench: driver pushes exact-sum expectations, monitor pops on each result handshake.
module tb_aca_error_recovery;
    localparam int WIDTH = 16;
    localparam int WIN   = 4;
    localparam int NB    = WIDTH / WIN;

    typedef struct {
        logic [WIDTH:0] res;
        logic           err;
        int             lat;
        logic [15:0]    cnt;
        int             acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   bp_mode = 2;
    logic [15:0] m_cnt = '0;
    exp_t sb[$];

    aca_error_recovery_if #(.WIDTH(WIDTH)) bus ();
    aca_error_recovery #(.WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flag reference: longest run of equal-position differing bits reaches WIN.
    function automatic logic ref_flag(input logic [WIDTH-1:0] p);
        int run = 0;
        for (int i = 0; i < WIDTH; i++) begin
            run = p[i] ? run + 1 : 0;
            if (run >= WIN) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        bus.ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                1:       bus.ready_i = 1'b0;
                2:       bus.ready_i = 1'b1;
                default: bus.ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.valid_o && !prev_v) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL spurious_valid: got valid_o=1 expected no result pending");
                    end else begin
                        chk("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
                    end
                end
                if (bus.valid_o && bus.ready_i && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("result", 32'(bus.result_o), 32'(e.res));
                    chk("err", 32'(bus.err_o), 32'(e.err));
                    chk("err_cnt", 32'(bus.err_cnt_o), 32'(e.cnt));
                end
                prev_v = bus.valid_o;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        int   t = 0;
        logic f;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.add1_i  = a;
        bus.add2_i  = b;
        while (!bus.ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ready_o) begin
            chk("accept_timeout", 32'(bus.ready_o), 32'd1);
            bus.valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.add1_i  = WIDTH'($urandom);
        bus.add2_i  = WIDTH'($urandom);
        if (push) begin
            f = ref_flag(a ^ b);
            if (f && m_cnt != 16'hFFFF) m_cnt++;
            sb.push_back('{res: {1'b0, a} + {1'b0, b}, err: f, lat: f ? 2 + NB : 2,
                           cnt: m_cnt, acc_cyc: cyc});
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !bus.ready_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   bp_res;
        int               t;
        bus.valid_i = 1'b0;
        bus.add1_i  = '0;
        bus.add2_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready_o), 1);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_result", 32'(bus.result_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_cnt", 32'(bus.err_cnt_o), 0);
        rst = 1'b0;

        bp_mode = 2;
        send(16'h0000, 16'h0001, 1);
        send(16'h29AF, 16'h7A1B, 1);
        send(16'h1100, 16'h1111, 1);
        send(16'h5555, 16'hAAAA, 1);
        send(16'hFFFF, 16'h0001, 1);
        wait_idle();

        // Backpressure: hold the result for 10 cycles while junk toggles on the inputs.
        bp_mode = 1;
        a = 16'h0F0F;
        b = 16'h00F0;
        bp_res = {1'b0, a} + {1'b0, b};
        send(a, b, 1);
        t = 0;
        while (!bus.valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.valid_i = 1'($urandom);
            bus.add1_i  = WIDTH'($urandom);
            bus.add2_i  = WIDTH'($urandom);
            chk("bp_valid", 32'(bus.valid_o), 1);
            chk("bp_ready", 32'(bus.ready_o), 0);
            chk("bp_result", 32'(bus.result_o), 32'(bp_res));
            chk("bp_err", 32'(bus.err_o), 1);
        end
        bus.valid_i = 1'b0;
        bp_mode = 2;
        wait_idle();
        @(negedge clk);
        chk("post_bp_valid", 32'(bus.valid_o), 0);
        chk("post_bp_ready", 32'(bus.ready_o), 1);

        // Abort in the second recovery cycle.
        send(16'h8943, 16'hFFFF, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_cnt = '0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.ready_o), 1);
        chk("abort_valid", 32'(bus.valid_o), 0);
        chk("abort_cnt", 32'(bus.err_cnt_o), 0);
        chk("abort_result", 32'(bus.result_o), 0);
        send(16'hABCD, 16'h0000, 1);
        wait_idle();

        bp_mode = 0;
        for (int n = 0; n < 60; n++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b = ~a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                1:       b = a;
                default: b = WIDTH'($urandom);
            endcase
            send(a, b, 1);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
